delta_adc_ctrl: RTL and testbench
=================================

DELTA_ADC_CTRL -- requirements
Module: delta_adc_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, width of the ADC estimate and next_value.
REQ-002 Parameter SETTLE_PERIODS, default 2, number of period_done pulses to wait after each load before sampling the comparator (legal range 1..255).
REQ-003 Parameter LOCK_REVERSALS, default 4, number of consecutive direction reversals that asserts locked (legal range 1..15).
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset (0 = reset).
REQ-006 Port start, input, 1: begin tracking; sampled only in IDLE.
REQ-007 Port stop, input, 1: abort tracking; return to IDLE.
REQ-008 Port period_done, input, 1: one-cycle pulse from the PWM at the end of each PWM period.
REQ-009 Port comp_in, input, 1: asynchronous comparator; 1 = analog input above DAC estimate.
REQ-010 Port step_size, input, 8: unsigned increment/decrement per update; sampled in SAMPLE.
REQ-011 Port next_value, output, WIDTH: current estimate, driven to the ADC value register.
REQ-012 Port enable, output, 1: one-cycle load strobe to the ADC value register.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port locked, output, 1: tracking has converged (reversal criterion met).

Function
REQ-015 comp_in shall pass through a 2-flop synchronizer; only the synchronized value is used.
REQ-016 FSM states: IDLE, LOAD, SETTLE, SAMPLE; IDLE -> LOAD on start; LOAD -> SETTLE always; SETTLE -> SAMPLE when settle count reaches SETTLE_PERIODS; SAMPLE -> LOAD always.
REQ-017 On start in IDLE, the estimate shall be set to 2^(WIDTH-1) (0x8000 at default), entering LOAD on the next edge.
REQ-018 enable shall be high for exactly the one cycle spent in LOAD and low in all other states; next_value equals the estimate register at all times.
REQ-019 SETTLE: settle counter cleared on entry; incremented on each period_done seen while in SETTLE; period_done during LOAD or SAMPLE is ignored.
REQ-020 SAMPLE: synced comp = 1 -> estimate += step_size, saturating at 2^WIDTH-1; synced comp = 0 -> estimate -= step_size, saturating at 0.
REQ-021 step_size = 0 shall leave the estimate unchanged but still produce the LOAD/enable pulse.
REQ-022 Reversal counter (4 bits): on each SAMPLE after the first since start, direction differing from the previous direction -> increment (saturating at 15); same direction -> clear to 0; first SAMPLE only records direction.
REQ-023 locked shall be high while reversal count >= LOCK_REVERSALS; cleared on start, stop and reset.
REQ-024 stop in any non-IDLE state shall force IDLE on the next edge; enable shall not assert in that cycle; the estimate and next_value hold their value.
REQ-025 stop has priority over start; start and stop together in IDLE leave the FSM in IDLE.
REQ-026 start while busy shall be ignored.

Reset
REQ-027 reset low shall immediately (asynchronously) force state IDLE, estimate/next_value = 0, enable = 0, busy = 0, locked = 0, settle and reversal counters = 0, synchronizer flops = 0.
REQ-028 Release of reset shall take effect on a clock edge; no output changes until start.

Verification
REQ-029 Start with comp_in=1, step_size=16, SETTLE_PERIODS=2: enable pulses with next_value 0x8000, then 0x8010 after two period_done pulses plus one SAMPLE cycle, then 0x8020.
REQ-030 Saturation: estimate 0xFFF8, comp=1, step 16 -> 0xFFFF; estimate 0x0005, comp=0, step 16 -> 0x0000; step_size 0 -> value held, enable still pulses.
REQ-031 Lock: comp alternating 1,0,1,0,1 per sample, LOCK_REVERSALS=4 -> locked rises at the 5th SAMPLE; two equal directions afterwards -> locked falls.
REQ-032 stop during SETTLE -> busy low next cycle, no further enable, next_value held; start+stop together in IDLE -> remains IDLE.
REQ-033 reset asserted mid-SETTLE -> all outputs 0 without a clock edge; start during busy -> no restart, estimate sequence unaffected.

Source files
------------

// File: rtl/delta_adc_ctrl_if.sv
// Control/status bundle between the tracking-ADC sequencer and its host, PWM and comparator.
// The host side drives the master modport; the sequencer uses the slave modport.
interface delta_adc_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             stop;
    logic             period_done;
    logic             comp_in;
    logic [7:0]       step_size;
    logic [WIDTH-1:0] next_value;
    logic             enable;
    logic             busy;
    logic             locked;

    modport master (
        output start, stop, period_done, comp_in, step_size,
        input  next_value, enable, busy, locked
    );

    modport slave (
        input  start, stop, period_done, comp_in, step_size,
        output next_value, enable, busy, locked
    );
endinterface

// File: rtl/delta_adc_ctrl.sv
// Delta (tracking) ADC sequencer: steps a DAC estimate up or down after each settle window,
// driven by a synchronized comparator, and flags lock once the direction keeps reversing.
module delta_adc_ctrl #(
    parameter int WIDTH          = 16,
    parameter int SETTLE_PERIODS = 2,
    parameter int LOCK_REVERSALS = 4
) (
    input logic             clk,
    input logic             reset,
    delta_adc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        SAMPLE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MID_SCALE     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [7:0]       SETTLE_TARGET = 8'(SETTLE_PERIODS);
    localparam logic [3:0]       LOCK_TARGET   = 4'(LOCK_REVERSALS);

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a, input logic [7:0] b);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {{(WIDTH-7){1'b0}}, b};
        if (sum[WIDTH]) begin
            sat_add = {WIDTH{1'b1}};
        end else begin
            sat_add = sum[WIDTH-1:0];
        end
    endfunction

    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] a, input logic [7:0] b);
        logic [WIDTH-1:0] b_ext;
        b_ext = {{(WIDTH-8){1'b0}}, b};
        if (a < b_ext) begin
            sat_sub = {WIDTH{1'b0}};
        end else begin
            sat_sub = a - b_ext;
        end
    endfunction

    // The first sample after start only establishes a direction to compare against.
    function automatic logic [3:0] rev_next(input logic first, input logic dir_prev,
                                            input logic dir_now, input logic [3:0] cnt);
        if (first) begin
            rev_next = cnt;
        end else if (dir_now != dir_prev) begin
            rev_next = (cnt == 4'hF) ? cnt : cnt + 4'd1;
        end else begin
            rev_next = 4'd0;
        end
    endfunction

    logic             comp_meta_r;
    logic             comp_sync_r;
    state_t           state_r;
    logic [WIDTH-1:0] estimate_r;
    logic [7:0]       settle_cnt_r;
    logic [3:0]       rev_cnt_r;
    logic             dir_r;
    logic             first_r;
    logic             enable_r;
    logic             busy_r;
    logic             locked_r;
    logic [3:0]       rev_calc_s;

    assign rev_calc_s     = rev_next(first_r, dir_r, comp_sync_r, rev_cnt_r);
    assign bus.next_value = estimate_r;
    assign bus.enable     = enable_r;
    assign bus.busy       = busy_r;
    assign bus.locked     = locked_r;

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            comp_meta_r <= 1'b0;
            comp_sync_r <= 1'b0;
        end else begin
            comp_meta_r <= bus.comp_in;
            comp_sync_r <= comp_meta_r;
        end
    end

    // Sequencer FSM with registered enable/busy/locked outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            estimate_r   <= {WIDTH{1'b0}};
            settle_cnt_r <= 8'd0;
            rev_cnt_r    <= 4'd0;
            dir_r        <= 1'b0;
            first_r      <= 1'b0;
            enable_r     <= 1'b0;
            busy_r       <= 1'b0;
            locked_r     <= 1'b0;
        end else if (bus.stop && (state_r != IDLE)) begin
            // Abort keeps the last estimate on next_value but drops lock status.
            state_r   <= IDLE;
            enable_r  <= 1'b0;
            busy_r    <= 1'b0;
            locked_r  <= 1'b0;
            rev_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_r      <= LOAD;
                        estimate_r   <= MID_SCALE;
                        settle_cnt_r <= 8'd0;
                        rev_cnt_r    <= 4'd0;
                        first_r      <= 1'b1;
                        enable_r     <= 1'b1;
                        busy_r       <= 1'b1;
                        locked_r     <= 1'b0;
                    end else begin
                        enable_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                LOAD: begin
                    state_r      <= SETTLE;
                    settle_cnt_r <= 8'd0;
                    enable_r     <= 1'b0;
                end
                SETTLE: begin
                    if (bus.period_done) begin
                        settle_cnt_r <= settle_cnt_r + 8'd1;
                        if ((settle_cnt_r + 8'd1) >= SETTLE_TARGET) begin
                            state_r <= SAMPLE;
                        end else begin
                            state_r <= SETTLE;
                        end
                    end else begin
                        state_r <= SETTLE;
                    end
                end
                SAMPLE: begin
                    estimate_r <= comp_sync_r ? sat_add(estimate_r, bus.step_size)
                                              : sat_sub(estimate_r, bus.step_size);
                    dir_r      <= comp_sync_r;
                    first_r    <= 1'b0;
                    rev_cnt_r  <= rev_calc_s;
                    locked_r   <= (rev_calc_s >= LOCK_TARGET);
                    state_r    <= LOAD;
                    enable_r   <= 1'b1;
                end
                default: begin
                    state_r  <= IDLE;
                    enable_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_delta_adc_ctrl.sv
// Scoreboard bench for delta_adc_ctrl: each expected load value is queued by the stimulus and
// checked by an independent monitor whenever enable pulses.
module tb_delta_adc_ctrl;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   model;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    delta_adc_ctrl_if #(.WIDTH(16)) ifc ();

    delta_adc_ctrl #(
        .WIDTH(16),
        .SETTLE_PERIODS(2),
        .LOCK_REVERSALS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every enable strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ifc.enable === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_enable: got next_value=%h, no load was expected", ifc.next_value);
            end else begin
                mon_exp = exp_q.pop_front();
                if (ifc.next_value !== mon_exp) begin
                    n_err++;
                    $display("FAIL load_value: got %h, expected %h", ifc.next_value, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic wait_enable();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifc.enable === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL enable_timeout: got no enable in 40 cycles, expected one");
        end
    endtask

    task automatic do_start();
        ifc.start = 1'b1;
        model = 32'h8000;
        exp_q.push_back(16'h8000);
        @(posedge clk);
        #1 ifc.start = 1'b0;
        wait_enable();
    endtask

    task automatic do_stop();
        ifc.stop = 1'b1;
        @(posedge clk);
        #1 ifc.stop = 1'b0;
        check("busy_after_stop", {31'd0, ifc.busy}, 32'd0);
    endtask

    // One full LOAD->SETTLE->SAMPLE->LOAD round; called right after a LOAD strobe.
    task automatic update(input logic comp, input logic [7:0] step, input logic exp_lock,
                          input logic poke_start);
        ifc.comp_in   = comp;
        ifc.step_size = step;
        if (comp) model = (model + int'(step) > 65535) ? 65535 : model + int'(step);
        else      model = (model < int'(step)) ? 0 : model - int'(step);
        exp_q.push_back(16'(model));
        @(posedge clk); #1 ifc.period_done = 1'b1;
        @(posedge clk); #1 ifc.period_done = 1'b0; ifc.start = poke_start;
        @(posedge clk); #1 ifc.period_done = 1'b1; ifc.start = 1'b0;
        @(posedge clk); #1 ifc.period_done = 1'b0;
        wait_enable();
        check("locked", {31'd0, ifc.locked}, {31'd0, exp_lock});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model = 0;
        reset = 1'b0;
        ifc.start = 1'b0;
        ifc.stop = 1'b0;
        ifc.period_done = 1'b0;
        ifc.comp_in = 1'b0;
        ifc.step_size = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_next_value", {16'd0, ifc.next_value}, 32'd0);
        check("rst_busy", {31'd0, ifc.busy}, 32'd0);
        check("rst_enable", {31'd0, ifc.enable}, 32'd0);
        check("rst_locked", {31'd0, ifc.locked}, 32'd0);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", {31'd0, ifc.busy}, 32'd0);
        check("idle_next_value", {16'd0, ifc.next_value}, 32'd0);

        // Basic tracking upward: 8000, 8010, 8020, then a start poke while busy gives 8030.
        do_start();
        update(1'b1, 8'd16, 1'b0, 1'b0);
        check("track_8010", {16'd0, ifc.next_value}, 32'h8010);
        update(1'b1, 8'd16, 1'b0, 1'b0);
        check("track_8020", {16'd0, ifc.next_value}, 32'h8020);
        update(1'b1, 8'd16, 1'b0, 1'b1);
        check("busy_start_8030", {16'd0, ifc.next_value}, 32'h8030);

        // Stop during SETTLE.
        @(posedge clk); #1 ifc.period_done = 1'b1;
        @(posedge clk); #1 ifc.period_done = 1'b0; ifc.stop = 1'b1;
        @(posedge clk); #1 ifc.stop = 1'b0;
        check("stop_busy", {31'd0, ifc.busy}, 32'd0);
        check("stop_hold", {16'd0, ifc.next_value}, 32'h8030);
        repeat (2) begin
            @(posedge clk); #1 ifc.period_done = 1'b1;
            @(posedge clk); #1 ifc.period_done = 1'b0;
        end
        repeat (8) @(posedge clk);
        #1 check("stop_stays_idle", {31'd0, ifc.busy}, 32'd0);

        // Start and stop together in IDLE.
        ifc.start = 1'b1; ifc.stop = 1'b1;
        @(posedge clk); #1 ifc.start = 1'b0; ifc.stop = 1'b0;
        check("startstop_busy", {31'd0, ifc.busy}, 32'd0);
        repeat (5) @(posedge clk);
        #1 check("startstop_hold", {16'd0, ifc.next_value}, 32'h8030);

        // Upper saturation.
        do_start();
        for (int i = 0; i < 128; i++) update(1'b1, 8'd255, 1'b0, 1'b0);
        update(1'b1, 8'd120, 1'b0, 1'b0);
        check("near_top", {16'd0, ifc.next_value}, 32'hFFF8);
        update(1'b1, 8'd16, 1'b0, 1'b0);
        check("sat_top", {16'd0, ifc.next_value}, 32'hFFFF);
        do_stop();

        // Lower saturation and zero step.
        do_start();
        for (int i = 0; i < 128; i++) update(1'b0, 8'd255, 1'b0, 1'b0);
        update(1'b0, 8'd123, 1'b0, 1'b0);
        check("near_bottom", {16'd0, ifc.next_value}, 32'h0005);
        update(1'b0, 8'd16, 1'b0, 1'b0);
        check("sat_bottom", {16'd0, ifc.next_value}, 32'h0000);
        update(1'b0, 8'd0, 1'b0, 1'b0);
        check("zero_step", {16'd0, ifc.next_value}, 32'h0000);
        do_stop();

        // Lock on alternating directions, unlock on a repeat.
        do_start();
        update(1'b1, 8'd16, 1'b0, 1'b0);
        update(1'b0, 8'd16, 1'b0, 1'b0);
        update(1'b1, 8'd16, 1'b0, 1'b0);
        update(1'b0, 8'd16, 1'b0, 1'b0);
        update(1'b1, 8'd16, 1'b1, 1'b0);
        update(1'b1, 8'd16, 1'b0, 1'b0);
        check("lock_value", {16'd0, ifc.next_value}, 32'h8020);

        // Asynchronous reset in the middle of SETTLE.
        @(posedge clk); #1 ifc.period_done = 1'b1;
        @(posedge clk); #1 ifc.period_done = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("areset_next_value", {16'd0, ifc.next_value}, 32'd0);
        check("areset_busy", {31'd0, ifc.busy}, 32'd0);
        check("areset_enable", {31'd0, ifc.enable}, 32'd0);
        check("areset_locked", {31'd0, ifc.locked}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("post_reset_busy", {31'd0, ifc.busy}, 32'd0);
        check("post_reset_value", {16'd0, ifc.next_value}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
